// File: rtl/cache_types_pkg.sv
// Shared types for the cache-side arbiter: FSM state encoding and channel-index width helper.
package cache_types_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // A single channel still needs a 1-bit index so vectors never collapse to zero width.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_arbiter_pick.sv
// Combinational winner picker: fixed lowest-index priority or round-robin from last+1.
// Zero latency; masked-out requesters are simply never chosen.
module arb_pick
    import cache_types_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = ch_idx_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [NUM_CH-1:0] i_excl,
    input  logic [IDX_W-1:0]  i_last,
    input  logic              i_rr,
    output logic [NUM_CH-1:0] o_win,
    output logic              o_vld
);

    logic [NUM_CH-1:0] w_cand;

    assign w_cand = i_req & ~i_excl;
    assign o_vld  = |w_cand;

    always_comb begin : pick
        logic found;
        int   pos;
        o_win = '0;
        found = 1'b0;
        pos   = 0;
        if (!i_rr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cand[i] && !found) begin
                    o_win[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end else begin
            // Walk positions last+1 .. last+NUM_CH, wrapping modulo NUM_CH (works for non-powers of 2).
            for (int k = 1; k <= NUM_CH; k++) begin
                pos = int'(i_last) + k;
                if (pos >= NUM_CH) pos = pos - NUM_CH;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (i == pos && w_cand[i] && !found) begin
                        o_win[i] = 1'b1;
                        found    = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/cache_arbiter.sv
// N-channel Wishbone-style arbiter muxing cache masters onto one downstream port.
// Grant registered one cycle after request; handoff on ack edge with no bubble; no preemption.
module cache_arbiter
    import cache_types_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 128,
    parameter int SEL_W   = DATA_W / 8,
    parameter int RR_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        s_cyc,
    input  logic [NUM_CH-1:0]        s_stb,
    input  logic [NUM_CH-1:0]        s_we,
    input  logic [NUM_CH*ADDR_W-1:0] s_adr,
    input  logic [NUM_CH*SEL_W-1:0]  s_sel,
    input  logic [NUM_CH*DATA_W-1:0] s_wdata,
    output logic [NUM_CH-1:0]        s_ack,
    output logic [DATA_W-1:0]        s_rdata,
    output logic                     m_cyc,
    output logic                     m_stb,
    output logic                     m_we,
    output logic [ADDR_W-1:0]        m_adr,
    output logic [SEL_W-1:0]         m_sel,
    output logic [DATA_W-1:0]        m_wdata,
    input  logic [DATA_W-1:0]        m_rdata,
    input  logic                     m_ack,
    output logic [NUM_CH-1:0]        grant
);

    localparam int IDX_W = ch_idx_w(NUM_CH);

    arb_state_t        r_state, w_state_nxt;
    logic [NUM_CH-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]  r_last, w_last_nxt;

    logic [NUM_CH-1:0] w_req;
    logic [NUM_CH-1:0] w_win;
    logic              w_win_vld;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_release;

    assign w_req = s_cyc & s_stb;

    // Excluding the current grant keeps the just-served channel from winning at its own ack edge.
    arb_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pick (
        .i_req  (w_req),
        .i_excl (r_gnt),
        .i_last (r_last),
        .i_rr   (RR_MODE != 0),
        .o_win  (w_win),
        .o_vld  (w_win_vld)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_win[i]) w_win_idx = IDX_W'(i);
        end
    end

    // Completion or abort (granted master dropped cyc) both release the grant.
    assign w_release = (r_state == BUSY) && (m_ack || !(|(r_gnt & s_cyc)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= IDX_W'(NUM_CH - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = BUSY;
                    w_gnt_nxt   = w_win;
                    w_last_nxt  = w_win_idx;
                end
            end
            BUSY: begin
                if (w_release) begin
                    if (w_win_vld) begin
                        w_gnt_nxt  = w_win;
                        w_last_nxt = w_win_idx;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // One-hot AND-OR mux; a zero grant (idle or reset) forces every output low.
    always_comb begin
        m_cyc   = 1'b0;
        m_stb   = 1'b0;
        m_we    = 1'b0;
        m_adr   = '0;
        m_sel   = '0;
        m_wdata = '0;
        s_ack   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_gnt[i]) begin
                m_cyc    = m_cyc | s_cyc[i];
                m_stb    = m_stb | s_stb[i];
                m_we     = m_we  | s_we[i];
                m_adr    = m_adr   | s_adr[i*ADDR_W +: ADDR_W];
                m_sel    = m_sel   | s_sel[i*SEL_W +: SEL_W];
                m_wdata  = m_wdata | s_wdata[i*DATA_W +: DATA_W];
                s_ack[i] = m_ack & s_cyc[i];
            end
        end
    end

    assign grant   = r_gnt;
    assign s_rdata = m_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench: 2-channel fixed-priority and 3-channel round-robin instances of cache_arbiter.
module tb_cache_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Fixed-priority, 2 channels
    logic [1:0]   f_cyc, f_stb, f_we, f_ack, f_grant;
    logic [31:0]  f_adr, f_sel;
    logic [255:0] f_wdata;
    logic [127:0] f_rdata, f_mwdata, f_mrdata;
    logic         f_mcyc, f_mstb, f_mwe, f_mack;
    logic [15:0]  f_madr, f_msel;

    // Round-robin, 3 channels
    logic [2:0]   r_cyc, r_stb, r_we, r_ack, r_grant;
    logic [47:0]  r_adr;
    logic [47:0]  r_sel;
    logic [383:0] r_wdata;
    logic [127:0] r_rdata, r_mwdata, r_mrdata;
    logic         r_mcyc, r_mstb, r_mwe, r_mack;
    logic [15:0]  r_madr, r_msel;

    cache_arbiter #(.NUM_CH(2), .RR_MODE(0)) u_fix (
        .clk(clk), .rst(rst),
        .s_cyc(f_cyc), .s_stb(f_stb), .s_we(f_we), .s_adr(f_adr), .s_sel(f_sel), .s_wdata(f_wdata),
        .s_ack(f_ack), .s_rdata(f_rdata),
        .m_cyc(f_mcyc), .m_stb(f_mstb), .m_we(f_mwe), .m_adr(f_madr), .m_sel(f_msel),
        .m_wdata(f_mwdata), .m_rdata(f_mrdata), .m_ack(f_mack), .grant(f_grant)
    );

    cache_arbiter #(.NUM_CH(3), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst),
        .s_cyc(r_cyc), .s_stb(r_stb), .s_we(r_we), .s_adr(r_adr), .s_sel(r_sel), .s_wdata(r_wdata),
        .s_ack(r_ack), .s_rdata(r_rdata),
        .m_cyc(r_mcyc), .m_stb(r_mstb), .m_we(r_mwe), .m_adr(r_madr), .m_sel(r_msel),
        .m_wdata(r_mwdata), .m_rdata(r_mrdata), .m_ack(r_mack), .grant(r_grant)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        f_cyc = '0; f_stb = '0; f_we = '0; f_adr = '0; f_sel = '0; f_wdata = '0;
        f_mrdata = '0; f_mack = 1'b0;
        r_cyc = '0; r_stb = '0; r_we = '0; r_sel = '0; r_wdata = '0;
        r_adr = {16'h00A2, 16'h00A1, 16'h00A0};
        r_mrdata = '0; r_mack = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_fgrant", 128'(f_grant), 128'h0);
        chk("rst_fmstb",  128'(f_mstb),  128'h0);
        chk("rst_fmadr",  128'(f_madr),  128'h0);
        chk("rst_rgrant", 128'(r_grant), 128'h0);
        rst = 1'b0;

        // Fixed priority: both request together
        tick();
        f_cyc = 2'b11; f_stb = 2'b11;
        f_adr = {16'h2222, 16'h1111};
        f_mrdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        tick();
        chk("fix_gnt_ch0",  128'(f_grant), 128'h1);
        chk("fix_madr_ch0", 128'(f_madr),  128'h1111);
        chk("fix_mstb",     128'(f_mstb),  128'h1);
        chk("rdata_pass",   f_rdata, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
        tick();
        tick();
        f_mack = 1'b1;
        #1;
        chk("fix_sack_ch0", 128'(f_ack), 128'h1);
        tick();
        chk("fix_gnt_ch1",  128'(f_grant), 128'h2);
        chk("fix_madr_ch1", 128'(f_madr),  128'h2222);
        f_mack = 1'b0; f_cyc = 2'b10; f_stb = 2'b10;
        tick();
        tick();
        f_mack = 1'b1;
        #1;
        chk("fix_sack_ch1", 128'(f_ack), 128'h2);
        tick();
        chk("fix_idle_gnt", 128'(f_grant), 128'h0);
        chk("fix_idle_stb", 128'(f_mstb),  128'h0);
        chk("fix_idle_adr", 128'(f_madr),  128'h0);
        f_mack = 1'b0; f_cyc = '0; f_stb = '0;

        // Just-served channel is not re-granted at its own ack edge
        tick();
        f_cyc = 2'b01; f_stb = 2'b01;
        tick();
        chk("regr_gnt0", 128'(f_grant), 128'h1);
        f_mack = 1'b1;
        tick();
        chk("regr_idle", 128'(f_grant), 128'h0);
        f_mack = 1'b0;
        tick();
        chk("regr_again", 128'(f_grant), 128'h1);
        f_mack = 1'b1;
        tick();
        f_mack = 1'b0; f_cyc = '0; f_stb = '0;
        chk("regr_done", 128'(f_grant), 128'h0);

        // Abort with ch0 pending and a late ack in the abort cycle
        tick();
        f_cyc = 2'b10; f_stb = 2'b10;
        tick();
        chk("abt_gnt1", 128'(f_grant), 128'h2);
        f_cyc = 2'b11; f_stb = 2'b11;
        tick();
        chk("no_preempt", 128'(f_grant), 128'h2);
        f_cyc = 2'b01; f_stb = 2'b01; f_mack = 1'b1;
        #1;
        chk("abt_sack", 128'(f_ack),  128'h0);
        chk("abt_mcyc", 128'(f_mcyc), 128'h0);
        tick();
        chk("abt_handoff", 128'(f_grant), 128'h1);
        f_mack = 1'b0;
        #1;
        f_mack = 1'b1;
        tick();
        f_mack = 1'b0; f_cyc = '0; f_stb = '0;
        chk("abt_done", 128'(f_grant), 128'h0);

        // Write path: ch1 values must reach m_* untouched by ch0's differing values
        tick();
        f_we = 2'b10;
        f_sel = {16'hFFFF, 16'h1234};
        f_wdata = {{16{8'hA5}}, {16{8'h3C}}};
        f_adr = {16'hBEEF, 16'h0C0C};
        f_cyc = 2'b10; f_stb = 2'b10;
        tick();
        chk("wr_gnt1",  128'(f_grant), 128'h2);
        chk("wr_mwe",   128'(f_mwe),   128'h1);
        chk("wr_msel",  128'(f_msel),  128'hFFFF);
        chk("wr_mdata", f_mwdata, {16{8'hA5}});
        f_cyc = 2'b11; f_stb = 2'b11;
        #1;
        chk("wr_mdata_hold", f_mwdata, {16{8'hA5}});
        chk("wr_madr_hold",  128'(f_madr), 128'hBEEF);
        f_mack = 1'b1;
        tick();
        chk("wr_gnt0",  128'(f_grant), 128'h1);
        chk("rd_mwe0",  128'(f_mwe),   128'h0);
        chk("rd_msel0", 128'(f_msel),  128'h1234);
        f_mack = 1'b0; f_cyc = 2'b01; f_stb = 2'b01;
        #1;
        f_mack = 1'b1;
        tick();
        f_mack = 1'b0; f_cyc = '0; f_stb = '0; f_we = '0;

        // Reset asserted mid-transaction with an ack present
        tick();
        f_cyc = 2'b01; f_stb = 2'b01;
        tick();
        chk("rstm_gnt0", 128'(f_grant), 128'h1);
        #2;
        rst = 1'b1; f_mack = 1'b1;
        #1;
        chk("rstm_gnt",  128'(f_grant), 128'h0);
        chk("rstm_mstb", 128'(f_mstb),  128'h0);
        chk("rstm_sack", 128'(f_ack),   128'h0);
        tick();
        chk("rstm_hold", 128'(f_grant), 128'h0);
        rst = 1'b0; f_mack = 1'b0; f_cyc = '0; f_stb = '0;
        tick();
        chk("rstm_idle", 128'(f_grant), 128'h0);

        // Round-robin, 3 channels, continuous requests, one-cycle transactions
        tick();
        r_cyc = 3'b111; r_stb = 3'b111; r_mack = 1'b1;
        tick();
        chk("rr_g0",    128'(r_grant), 128'h1);
        chk("rr_ack0",  128'(r_ack),   128'h1);
        chk("rr_stb0",  128'(r_mstb),  128'h1);
        tick();
        chk("rr_g1",    128'(r_grant), 128'h2);
        chk("rr_stb1",  128'(r_mstb),  128'h1);
        tick();
        chk("rr_g2",    128'(r_grant), 128'h4);
        chk("rr_adr2",  128'(r_madr),  128'h00A2);
        tick();
        chk("rr_wrap",  128'(r_grant), 128'h1);
        chk("rr_stb3",  128'(r_mstb),  128'h1);
        r_cyc = '0; r_stb = '0; r_mack = 1'b0;
        tick();
        chk("rr_idle",  128'(r_grant), 128'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Parametrised N-channel arbiter multiplexing cache-side Wishbone-style masters (stb/cyc/we/ack) onto one downstream port (L2 cache or physical memory). Generalises the two-channel I/D interconnect controller with a configurable channel count, selectable fixed or round-robin priority, and integrated address/data/select muxing. It also supports back-to-back grant handoff and abort handling.

## Interface
- NUM_CH, 2: number of upstream masters (2..8); channel 0 is the I-cache.
- ADDR_W, 16: address width.
- DATA_W, 128: line data width.
- SEL_W, DATA_W/8: byte-select width.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_cyc  in  NUM_CH  per-channel cycle.
- s_stb  in  NUM_CH  per-channel strobe.
- s_we  in  NUM_CH  per-channel write enable.
- s_adr  in  NUM_CH*ADDR_W  packed addresses; channel i at [i*ADDR_W +: ADDR_W].
- s_sel  in  NUM_CH*SEL_W  packed byte selects.
- s_wdata  in  NUM_CH*DATA_W  packed write data.
- s_ack  out  NUM_CH  per-channel ack.
- s_rdata  out  DATA_W  read data, broadcast to all channels.
- m_cyc, m_stb, m_we  out  1 each  downstream controls.
- m_adr  out  ADDR_W  downstream address.
- m_sel  out  SEL_W  downstream byte select.
- m_wdata  out  DATA_W  downstream write data.
- m_rdata  in  DATA_W  downstream read data.
- m_ack  in  1  downstream ack.
- grant  out  NUM_CH  one-hot current grant; all zero when idle (debug/perf).

## Operation
- Request: req[i] = s_cyc[i] & s_stb[i].
- States: IDLE and BUSY. Registered grant one-hot `gnt` and pointer `last` (index of the most recently granted channel).
- IDLE:
  - If any req is asserted, pick a winner, load `gnt`, set `last` to the winner, and move to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - m_cyc, m_stb, m_we, m_adr, m_sel, and m_wdata come from the granted channel.
  - s_ack[g] = m_ack; all other s_ack bits are 0.
- Winner selection:
  - Fixed mode: lowest-index asserted req.
  - RR mode: first asserted req searching from (last+1) mod NUM_CH upward with wrap.
- Completion (BUSY & m_ack): choose the next winner among requests excluding the current channel.
  - If one exists, hand off directly (stay in BUSY, new `gnt`, update `last`).
  - Otherwise go to IDLE.
- Abort: in BUSY with s_cyc[g]=0 and no m_ack, release the grant using the completion rules (handoff or IDLE). Any m_ack arriving after the abort is dropped.
- Outputs in IDLE: m_cyc, m_stb, and m_we are 0; m_adr, m_sel, and m_wdata are 0; s_ack is all 0.
- s_rdata = m_rdata, unconditionally.

## Timing
- Reset (async assert): state IDLE, gnt=0, last=NUM_CH-1, so RR mode starts at channel 0. All outputs are driven to 0 immediately, without waiting for a clock.
- Arbitration latency:
  - A req visible at edge k drives m_stb from cycle k+1.
  - s_ack is combinational from m_ack, in the same cycle.
- Handoff: on the ack edge, the new grantee's m_stb is asserted in the very next cycle, with no idle bubble.
- Simultaneous ack and new requests: the just-served channel is never re-granted at that edge, even if its stb is still high. It may win again from IDLE or after another channel is served.
- Grant is stable while in BUSY; requests arriving mid-transaction do not preempt.
- Reset asserted mid-transaction: the grant drops and s_ack is forced to 0. A downstream ack arriving during reset is ignored.
- Widths: the channel index is $clog2(NUM_CH) bits. Round-robin wrap is computed modulo NUM_CH and is correct for non-power-of-2 counts.

## Structure
- Shared package `cache_types_pkg` holds:
  - the `arb_state_t` enum {IDLE, BUSY};
  - the channel-index width function/constant.
- One sub-module is natural: `arb_pick`, a combinational priority/round-robin picker.
  - Inputs: req vector, exclude mask, last pointer, mode.
  - Outputs: one-hot winner and valid.
  - It is shared by the IDLE and handoff paths.
- Top level contains the state/grant registers and the one-hot AND-OR muxes for the m_* outputs and s_ack.

## Test plan
- Reset/idle: assert rst mid-BUSY → grant=0, m_stb=0, and s_ack=0 immediately; after release, state is IDLE with no requests.
- Fixed priority, NUM_CH=2, RR_MODE=0: ch0 and ch1 request together at cycle 0 → grant=01 at cycle 1.
  - m_ack at cycle 3 → s_ack=01, and grant=10 at cycle 4 with m_adr=ch1 address.
  - m_ack at cycle 6 → IDLE at cycle 7.
- Round-robin, NUM_CH=3, RR_MODE=1: all three channels request continuously, with m_ack held one cycle per transaction → grant sequence 001, 010, 100, 001, with no bubble cycles.
- No re-grant of just-served channel: ch0 alone requests and holds stb one cycle past its ack → the arbiter goes to IDLE, then re-grants ch0 one cycle later.
- Abort: ch1 is granted, drops s_cyc before ack, and ch0 is pending → grant=01 the next cycle. A late m_ack in the abort cycle yields s_ack=00.
- Write path: ch1 we=1, s_sel=0xFFFF, and wdata pattern A5… → m_we=1 and m_sel/m_wdata match ch1 exactly while granted; ch0's differing values never appear on the m_* outputs.
